// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: word width, NOP encoding, PC step and the
// {instruction, PC+4} pair held by the fetch queue.
package pipeline_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pcplus;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of fetch-queue signals: instruction memory request/response,
// decode redirect/pop controls and the head entry presented to decode.
// The slave modport is the queue itself; master is the surrounding pipeline.
interface fetch_queue_if import pipeline_pkg::*; #(
  parameter int DEPTH = 4
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0] ImemAddr;
  logic [WORD_W-1:0] ImemData;
  logic              ImemReady;
  logic              RedirectD;
  logic [WORD_W-1:0] RedirectPC;
  logic              PopD;
  logic [WORD_W-1:0] InstrF;
  logic [WORD_W-1:0] PCPlusF;
  logic              ValidF;
  logic [CNT_W-1:0]  Count;

  modport slave (
    input  ImemData, ImemReady, RedirectD, RedirectPC, PopD,
    output ImemAddr, InstrF, PCPlusF, ValidF, Count
  );

  modport master (
    output ImemData, ImemReady, RedirectD, RedirectPC, PopD,
    input  ImemAddr, InstrF, PCPlusF, ValidF, Count
  );

endinterface

// File: rtl/fetch_queue_ram.sv
// DEPTH x fetch_entry_t register array: one synchronous write port and one
// asynchronous read port. Contents are never reset; occupancy tracking in
// the parent decides which entries are meaningful.
module fetch_queue_ram import pipeline_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  fetch_entry_t       wdata,
  input  logic [PTR_W-1:0]   raddr,
  output fetch_entry_t       rdata
);

  fetch_entry_t mem [DEPTH];

  // Write the incoming entry at the tail slot.
  // NOTE: storage has no reset branch; this keeps it a plain register file
  // and no reader ever looks at a slot that was not written first.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue. Owns the fetch PC, fills a DEPTH-entry FIFO of
// {instruction, PC+4} pairs from instruction memory and presents the head to
// decode. A decode redirect flushes the queue and restarts fetch at the target.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward the memory word
// straight to decode when the queue is empty.
module fetch_queue import pipeline_pkg::*; #(
  parameter int                DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WORD_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              valid;
  logic              pop;
  logic              push;       // word accepted from memory, FetchPC advances
  logic              write;      // accepted word is stored in the array
  fetch_entry_t      wr_entry;
  fetch_entry_t      head_entry;

  // Low two target bits are dropped: fetch is always word aligned.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^bus.RedirectPC[1:0];

  assign valid    = (count != '0);
  assign pop      = bus.PopD && valid && !bus.RedirectD;
  assign push     = bus.ImemReady && !bus.RedirectD && ((count < FULL_CNT) || pop);
  assign wr_entry = '{instr: bus.ImemData, pcplus: fetch_pc + PC_STEP};

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = !valid && bus.ImemReady && !bus.RedirectD;
  // A forwarded word that decode takes immediately never touches storage.
  assign write      = push && !(bypass_hit && bus.PopD);
`else
  assign write      = push;
`endif

  fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (write),
    .waddr (tail),
    .wdata (wr_entry),
    .raddr (head),
    .rdata (head_entry)
  );

  // Fetch PC, pointers and occupancy; redirect overrides push and pop.
  // NOTE: non-blocking assignments so every register sees the pre-edge
  // values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (bus.RedirectD) begin
      fetch_pc <= {bus.RedirectPC[WORD_W-1:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push)  fetch_pc <= fetch_pc + PC_STEP;
      if (write) tail     <= tail + PTR_W'(1);
      if (pop)   head     <= head + PTR_W'(1);
      case ({write, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Present the head entry to decode, or a NOP when nothing is queued.
  // NOTE: every output gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    bus.InstrF  = NOP_INSTR;
    bus.PCPlusF = '0;
    bus.ValidF  = 1'b0;
    if (valid) begin
      bus.InstrF  = head_entry.instr;
      bus.PCPlusF = head_entry.pcplus;
      bus.ValidF  = 1'b1;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (bypass_hit) begin
      bus.InstrF  = bus.ImemData;
      bus.PCPlusF = fetch_pc + PC_STEP;
      bus.ValidF  = 1'b1;
    end
`endif
  end

  assign bus.ImemAddr = fetch_pc;
  assign bus.Count    = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4, RESET_PC=0, bypass not compiled in).
// Memory model: the word at address A is 32'hA500_0000 + A, driven before
// each rising edge from the current ImemAddr.
module tb_fetch_queue;
  import pipeline_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fetch_queue_if #(.DEPTH(4)) bus ();

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present memory data for the current address, take one edge, settle at negedge.
  task automatic step();
    bus.ImemData = 32'hA500_0000 + bus.ImemAddr;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset          = 1'b0;
    bus.ImemReady  = 1'b1;
    bus.ImemData   = 32'h0;
    bus.PopD       = 1'b0;
    bus.RedirectD  = 1'b0;
    bus.RedirectPC = 32'h0;
    @(negedge clk);

    // Reset state
    check("rst_valid", 32'(bus.ValidF), 32'h0);
    check("rst_count", 32'(bus.Count), 32'h0);
    check("rst_addr", bus.ImemAddr, 32'h0);
    check("rst_instr", bus.InstrF, 32'h0);
    check("rst_pcplus", bus.PCPlusF, 32'h0);

    // Reset and fill: address steps 4, 8, 12, 16 while count climbs to 4
    reset = 1'b1;
    check("fill_addr0", bus.ImemAddr, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("fill_addr%0d", i), bus.ImemAddr, 32'(4 * i));
      check($sformatf("fill_count%0d", i), 32'(bus.Count), 32'(i));
    end
    check("fill_head_instr", bus.InstrF, 32'hA500_0000);
    check("fill_head_pcplus", bus.PCPlusF, 32'h4);
    step();
    step();
    check("full_hold_count", 32'(bus.Count), 32'h4);
    check("full_hold_addr", bus.ImemAddr, 32'h10);

    // Full with steady consumer: push+pop each edge, count stays 4
    bus.PopD = 1'b1;
    check("stream_pcplus0", bus.PCPlusF, 32'h4);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("stream_pcplus%0d", k), bus.PCPlusF, 32'(4 + 4 * k));
      check($sformatf("stream_count%0d", k), 32'(bus.Count), 32'h4);
    end
    check("stream_instr", bus.InstrF, 32'hA500_000C);
    check("stream_addr", bus.ImemAddr, 32'h1C);

    // Drain one with memory stalled: count 3
    bus.ImemReady = 1'b0;
    step();
    check("partial_count", 32'(bus.Count), 32'h3);
    check("partial_addr", bus.ImemAddr, 32'h1C);

    // Redirect while partly full: target 0x43 aligns to 0x40
    bus.PopD       = 1'b0;
    bus.ImemReady  = 1'b1;
    bus.RedirectD  = 1'b1;
    bus.RedirectPC = 32'h0000_0043;
    step();
    bus.RedirectD = 1'b0;
    check("redir_count", 32'(bus.Count), 32'h0);
    check("redir_valid", 32'(bus.ValidF), 32'h0);
    check("redir_addr", bus.ImemAddr, 32'h40);
    check("redir_instr", bus.InstrF, 32'h0);
    step();
    check("redir_pcplus", bus.PCPlusF, 32'h44);
    check("redir_first_instr", bus.InstrF, 32'hA500_0040);
    check("redir_first_valid", 32'(bus.ValidF), 32'h1);

    // Empty the queue with memory stalled
    bus.PopD      = 1'b1;
    bus.ImemReady = 1'b0;
    step();
    check("drain_valid", 32'(bus.ValidF), 32'h0);
    check("drain_addr", bus.ImemAddr, 32'h44);

    // Wait states: ImemReady 1,0,1,0 with PopD held; PCPlusF 0x48 then 0x4C
    bus.ImemReady = 1'b1;
    step();
    check("ws1_valid", 32'(bus.ValidF), 32'h1);
    check("ws1_pcplus", bus.PCPlusF, 32'h48);
    bus.ImemReady = 1'b0;
    step();
    check("ws2_valid", 32'(bus.ValidF), 32'h0);
    bus.ImemReady = 1'b1;
    step();
    check("ws3_valid", 32'(bus.ValidF), 32'h1);
    check("ws3_pcplus", bus.PCPlusF, 32'h4C);
    bus.ImemReady = 1'b0;
    step();
    check("ws4_valid", 32'(bus.ValidF), 32'h0);
    check("ws4_addr", bus.ImemAddr, 32'h4C);

    // Refill two entries, then redirect collides with push and pop
    bus.PopD      = 1'b0;
    bus.ImemReady = 1'b1;
    step();
    step();
    check("pre_coll_count", 32'(bus.Count), 32'h2);
    bus.PopD       = 1'b1;
    bus.RedirectD  = 1'b1;
    bus.RedirectPC = 32'h0000_0200;
    step();
    bus.RedirectD = 1'b0;
    bus.PopD      = 1'b0;
    check("coll_count", 32'(bus.Count), 32'h0);
    check("coll_valid", 32'(bus.ValidF), 32'h0);
    check("coll_addr", bus.ImemAddr, 32'h200);

    // Asynchronous reset mid-operation
    step();
    step();
    check("pre_arst_count", 32'(bus.Count), 32'h2);
    check("pre_arst_pcplus", bus.PCPlusF, 32'h204);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", 32'(bus.ValidF), 32'h0);
    check("arst_instr", bus.InstrF, 32'h0);
    check("arst_count", 32'(bus.Count), 32'h0);
    check("arst_addr", bus.ImemAddr, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("post_arst_addr", bus.ImemAddr, 32'h4);
    check("post_arst_pcplus", bus.PCPlusF, 32'h4);

    // PC wrap: PC+4 from 0xFFFFFFFC is 0
    bus.RedirectD  = 1'b1;
    bus.RedirectPC = 32'hFFFF_FFFF;
    step();
    bus.RedirectD = 1'b0;
    check("wrap_addr_target", bus.ImemAddr, 32'hFFFF_FFFC);
    step();
    check("wrap_pcplus", bus.PCPlusF, 32'h0);
    check("wrap_addr", bus.ImemAddr, 32'h0);
    check("wrap_valid", 32'(bus.ValidF), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
